// File: rtl/obj_line_walker.sv
// Per-scanline OBJ pixel walker: tests one descriptor against vcount and
// streams one beat per on-screen local pixel to the OBJ flip unit.
module obj_line_walker (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       flush,
  input  logic [7:0] vcount,
  input  logic       obj_valid,
  output logic       obj_ready,
  input  logic [8:0] obj_x,
  input  logic [7:0] obj_y,
  input  logic [7:0] obj_hsize,
  input  logic [7:0] obj_vsize,
  input  logic       obj_hflip,
  input  logic       obj_vflip,
  output logic       pix_valid,
  input  logic       pix_ready,
  output logic [5:0] pix_x,
  output logic [5:0] pix_y,
  output logic [7:0] pix_hsize,
  output logic [7:0] pix_vsize,
  output logic       pix_hflip,
  output logic       pix_vflip,
  output logic [7:0] pix_screen_x,
  output logic       pix_last,
  output logic       obj_done,
  output logic       obj_hit
);

  // state | meaning
  // IDLE  | waiting for a descriptor, obj_ready high
  // WALK  | stepping lx across the sprite, beats for on-screen pixels
  // DONE  | one-cycle obj_done pulse, obj_hit = latched hit
  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

  state_t     state;
  logic [5:0] lx;
  logic [5:0] ly_r;
  logic [8:0] x_r;
  logic [7:0] hsize_r;
  logic [7:0] vsize_r;
  logic       hflip_r;
  logic       vflip_r;
  logic       hit_r;

  logic [8:0] sx;
  logic       on_screen;
  logic       lx_end;
  logic       lx_stop;
  logic       advance;
  logic       accept;
  logic [7:0] ly_in;
  logic       hit_in;

  assign sx        = x_r + {3'b000, lx};
  assign on_screen = (sx < 9'd240);
  assign lx_end    = ({2'b00, lx} == (hsize_r - 8'd1));
  // Illegal sizes must not let lx wrap past the 6-bit local range.
  assign lx_stop   = lx_end || (lx == 6'd63);
  assign advance   = (state == WALK) && (!on_screen || pix_ready);
  assign accept    = obj_valid && (state == IDLE) && !flush;
  assign ly_in     = vcount - obj_y;
  assign hit_in    = (ly_in < obj_vsize);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      lx      <= 6'd0;
      ly_r    <= 6'd0;
      x_r     <= 9'd0;
      hsize_r <= 8'd0;
      vsize_r <= 8'd0;
      hflip_r <= 1'b0;
      vflip_r <= 1'b0;
      hit_r   <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            x_r     <= obj_x;
            hsize_r <= obj_hsize;
            vsize_r <= obj_vsize;
            hflip_r <= obj_hflip;
            vflip_r <= obj_vflip;
            ly_r    <= ly_in[5:0];
            hit_r   <= hit_in;
            lx      <= 6'd0;
            state   <= hit_in ? WALK : DONE;
          end
        end
        WALK: begin
          if (advance) begin
            if (lx_stop) state <= DONE;
            else         lx    <= lx + 6'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign obj_ready    = (state == IDLE);
  assign pix_valid    = (state == WALK) && on_screen;
  assign pix_x        = lx;
  assign pix_y        = ly_r;
  assign pix_hsize    = hsize_r;
  assign pix_vsize    = vsize_r;
  assign pix_hflip    = hflip_r;
  assign pix_vflip    = vflip_r;
  assign pix_screen_x = sx[7:0];
  assign pix_last     = (state == WALK) && lx_end;
  assign obj_done     = (state == DONE);
  assign obj_hit      = (state == DONE) && hit_r;

endmodule

// File: tb/tb_obj_line_walker.sv
// Bench for obj_line_walker: directed vector table, flush/reset sequences and
// randomized descriptors checked against a per-pixel list model.
module tb_obj_line_walker;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] vcount = '0;
  logic       obj_valid = 1'b0;
  logic       obj_ready;
  logic [8:0] obj_x = '0;
  logic [7:0] obj_y = '0;
  logic [7:0] obj_hsize = '0;
  logic [7:0] obj_vsize = '0;
  logic       obj_hflip = 1'b0;
  logic       obj_vflip = 1'b0;
  logic       pix_valid;
  logic       pix_ready = 1'b1;
  logic [5:0] pix_x;
  logic [5:0] pix_y;
  logic [7:0] pix_hsize;
  logic [7:0] pix_vsize;
  logic       pix_hflip;
  logic       pix_vflip;
  logic [7:0] pix_screen_x;
  logic       pix_last;
  logic       obj_done;
  logic       obj_hit;

  int checks = 0;
  int errors = 0;

  obj_line_walker dut (
    .clock(clock), .reset_n(reset_n), .flush(flush), .vcount(vcount),
    .obj_valid(obj_valid), .obj_ready(obj_ready), .obj_x(obj_x), .obj_y(obj_y),
    .obj_hsize(obj_hsize), .obj_vsize(obj_vsize), .obj_hflip(obj_hflip),
    .obj_vflip(obj_vflip), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_hsize(pix_hsize), .pix_vsize(pix_vsize),
    .pix_hflip(pix_hflip), .pix_vflip(pix_vflip), .pix_screen_x(pix_screen_x),
    .pix_last(pix_last), .obj_done(obj_done), .obj_hit(obj_hit)
  );

  always #5 clock = ~clock;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] vc;
    logic [8:0] x;
    logic [7:0] y;
    logic [7:0] hs;
    logic [7:0] vs;
    logic       hf;
    logic       vf;
  } desc_t;

  typedef struct {
    int nbeats;
    int first_px;
    int first_sx;
    int py;
    int last_seen;
    int done_cyc;
    int hit;
  } res_t;

  typedef struct {
    desc_t d;
    res_t  e;
  } vec_t;

  typedef struct {
    int px;
    int py;
    int sx;
    int last;
  } beat_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Caller is at a negedge with the walker idle; returns at a negedge, idle.
  task automatic run_obj(input desc_t d, input int mode, output res_t r);
    beat_t q[$];
    int    stalls = 0;
    int    cyc = 0;
    int    phase = 0;
    bit    done = 1'b0;
    bit    rdy;
    bit    exp_hit;
    int    ly;
    ly      = (int'(d.vc) - int'(d.y) + 256) % 256;
    exp_hit = (ly < int'(d.vs));
    if (exp_hit) begin
      for (int i = 0; i < int'(d.hs); i++) begin
        int s;
        s = (int'(d.x) + i) % 512;
        if (s < 240) q.push_back('{i, ly % 64, s, (i == int'(d.hs) - 1) ? 1 : 0});
      end
    end
    r = '{0, -1, -1, -1, 0, -1, 0};
    vcount = d.vc; obj_x = d.x; obj_y = d.y; obj_hsize = d.hs; obj_vsize = d.vs;
    obj_hflip = d.hf; obj_vflip = d.vf; obj_valid = 1'b1;
    @(posedge clock);
    #1 obj_valid = 1'b0;
    while (!done && cyc < 400) begin
      @(negedge clock);
      cyc++;
      if (mode == 0)      rdy = 1'b1;
      else if (mode == 1) rdy = (phase % 3 == 0);
      else                rdy = 1'($urandom_range(0, 1));
      phase++;
      pix_ready = rdy;
      if (pix_valid) begin
        if (q.size() == 0) begin
          check("extra_beat", int'(pix_x), -1);
        end else begin
          check("pix_x", int'(pix_x), q[0].px);
          check("pix_y", int'(pix_y), q[0].py);
          check("pix_screen_x", int'(pix_screen_x), q[0].sx);
          check("pix_last", int'(pix_last), q[0].last);
          check("pix_meta", int'({pix_hsize, pix_vsize, pix_hflip, pix_vflip}),
                int'({d.hs, d.vs, d.hf, d.vf}));
          if (rdy) begin
            if (r.nbeats == 0) begin
              r.first_px = int'(pix_x);
              r.first_sx = int'(pix_screen_x);
              r.py       = int'(pix_y);
            end
            if (pix_last) r.last_seen = 1;
            r.nbeats++;
            void'(q.pop_front());
          end else begin
            stalls++;
          end
        end
      end
      if (obj_done) begin
        done       = 1'b1;
        r.done_cyc = cyc;
        r.hit      = int'(obj_hit);
      end
    end
    pix_ready = 1'b1;
    check("done_seen", int'(done), 1);
    check("beats_left", q.size(), 0);
    check("obj_hit_model", r.hit, int'(exp_hit));
    check("done_cycle_model", r.done_cyc, exp_hit ? int'(d.hs) + stalls + 1 : 1);
    @(negedge clock);
    check("ready_after_done", int'(obj_ready), 1);
  endtask

  task automatic start_obj(input desc_t d);
    vcount = d.vc; obj_x = d.x; obj_y = d.y; obj_hsize = d.hs; obj_vsize = d.vs;
    obj_hflip = d.hf; obj_vflip = d.vf; obj_valid = 1'b1;
    @(posedge clock);
    #1 obj_valid = 1'b0;
  endtask

  task automatic wait_px3(output bit found);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      if (pix_valid && pix_x == 6'd3) found = 1'b1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_obj_ready"}, int'(obj_ready), 1);
    check({tag, "_pix_valid"}, int'(pix_valid), 0);
    check({tag, "_pix_last"}, int'(pix_last), 0);
    check({tag, "_obj_done"}, int'(obj_done), 0);
    check({tag, "_obj_hit"}, int'(obj_hit), 0);
    check({tag, "_fields"}, int'({pix_x, pix_y, pix_hsize, pix_vsize, pix_hflip, pix_vflip}), 0);
    check({tag, "_screen_x"}, int'(pix_screen_x), 0);
  endtask

  vec_t  vec[8];
  res_t  r;
  desc_t d;
  bit    found;
  int    done_cnt;

  initial begin
    vec[0] = '{'{8'd50, 9'd10, 8'd45, 8'd8, 8'd8, 1'b0, 1'b1}, '{8, 0, 10, 5, 1, 9, 1}};
    vec[1] = '{'{8'd50, 9'd10, 8'd60, 8'd16, 8'd16, 1'b1, 1'b0}, '{0, -1, -1, -1, 0, 1, 0}};
    vec[2] = '{'{8'd3, 9'd20, 8'd250, 8'd8, 8'd16, 1'b1, 1'b1}, '{8, 0, 20, 9, 1, 9, 1}};
    vec[3] = '{'{8'd10, 9'd500, 8'd0, 8'd16, 8'd16, 1'b0, 1'b0}, '{4, 12, 0, 10, 1, 17, 1}};
    vec[4] = '{'{8'd10, 9'd236, 8'd0, 8'd8, 8'd16, 1'b1, 1'b0}, '{4, 0, 236, 10, 0, 9, 1}};
    vec[5] = '{'{8'd100, 9'd200, 8'd90, 8'd64, 8'd64, 1'b0, 1'b1}, '{40, 0, 200, 10, 0, 65, 1}};
    vec[6] = '{'{8'd57, 9'd0, 8'd50, 8'd8, 8'd8, 1'b0, 1'b0}, '{8, 0, 0, 7, 1, 9, 1}};
    vec[7] = '{'{8'd58, 9'd0, 8'd50, 8'd8, 8'd8, 1'b0, 1'b0}, '{0, -1, -1, -1, 0, 1, 0}};

    #1 check_reset_outputs("reset");
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    foreach (vec[k]) begin
      run_obj(vec[k].d, 0, r);
      check($sformatf("v%0d_nbeats", k), r.nbeats, vec[k].e.nbeats);
      check($sformatf("v%0d_first_px", k), r.first_px, vec[k].e.first_px);
      check($sformatf("v%0d_first_sx", k), r.first_sx, vec[k].e.first_sx);
      check($sformatf("v%0d_pix_y", k), r.py, vec[k].e.py);
      check($sformatf("v%0d_last_seen", k), r.last_seen, vec[k].e.last_seen);
      check($sformatf("v%0d_done_cyc", k), r.done_cyc, vec[k].e.done_cyc);
      check($sformatf("v%0d_hit", k), r.hit, vec[k].e.hit);
    end

    // Backpressure with ready pattern 1,0,0,1,0,0...
    run_obj(vec[0].d, 1, r);
    check("bp_nbeats", r.nbeats, 8);
    check("bp_first_px", r.first_px, 0);
    check("bp_done_after_stalls", int'(r.done_cyc > 9), 1);

    // Flush at pix_x == 3 of a 32-wide OBJ.
    d = '{8'd50, 9'd10, 8'd45, 8'd32, 8'd32, 1'b0, 1'b0};
    start_obj(d);
    wait_px3(found);
    check("flush_reached_px3", int'(found), 1);
    flush = 1'b1;
    @(posedge clock);
    #1 flush = 1'b0;
    @(negedge clock);
    check("flush_obj_ready", int'(obj_ready), 1);
    check("flush_pix_valid", int'(pix_valid), 0);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (obj_done) done_cnt++;
      @(negedge clock);
    end
    check("flush_no_done", done_cnt, 0);

    // Descriptor presented together with flush is not accepted.
    vcount = 8'd50; obj_x = 9'd10; obj_y = 8'd45; obj_hsize = 8'd8; obj_vsize = 8'd8;
    obj_valid = 1'b1; flush = 1'b1;
    @(posedge clock);
    #1 begin obj_valid = 1'b0; flush = 1'b0; end
    @(negedge clock);
    check("flush_acc_ready", int'(obj_ready), 1);
    check("flush_acc_valid", int'(pix_valid), 0);
    check("flush_acc_done", int'(obj_done), 0);

    // Asynchronous reset mid-walk.
    start_obj(d);
    wait_px3(found);
    check("reset_reached_px3", int'(found), 1);
    reset_n = 1'b0;
    #1 check_reset_outputs("midreset");
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    for (int n = 0; n < 40; n++) begin
      desc_t rd;
      int    sz[4];
      sz = '{8, 16, 32, 64};
      rd.vc = 8'($urandom_range(0, 255));
      rd.y  = rd.vc - 8'($urandom_range(0, 90));
      rd.x  = 9'($urandom_range(0, 511));
      rd.hs = 8'(sz[$urandom_range(0, 3)]);
      rd.vs = 8'(sz[$urandom_range(0, 3)]);
      rd.hf = 1'($urandom_range(0, 1));
      rd.vf = 1'($urandom_range(0, 1));
      run_obj(rd, int'($urandom_range(0, 2)), r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/obj_line_walker.md
# obj_line_walker

Per-scanline OBJ pixel walker for the sprite pipeline. It accepts one OBJ descriptor at a time and decides whether the current scanline `vcount` hits the sprite. On a hit it walks the sprite's local x coordinate from 0 to `hsize-1` and emits one pixel beat per on-screen pixel, carrying unflipped local `(x, y)`, sizes and flip bits. The beat stream feeds the OBJ flip unit directly; the flip unit's result then addresses tile VRAM.

## Interface
- No parameters. Screen width is fixed at 240 and the vertical wrap at 256.
- `clock` in 1: system clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous abort; the walker returns to IDLE and no `obj_done` pulse is issued.
- `vcount` in 8: current scanline; must be stable while an OBJ is in flight.
- `obj_valid` in 1: descriptor present.
- `obj_ready` out 1: walker can accept a descriptor; high iff state is IDLE.
- `obj_x` in 9: OBJ screen X, two's-complement mod 512.
- `obj_y` in 8: OBJ screen Y, mod 256.
- `obj_hsize` in 8: width in pixels; only 8, 16, 32 or 64 is legal.
- `obj_vsize` in 8: height in pixels; only 8, 16, 32 or 64 is legal.
- `obj_hflip` in 1: horizontal flip bit, carried to the pixel beats.
- `obj_vflip` in 1: vertical flip bit, carried to the pixel beats.
- `pix_valid` out 1: pixel beat valid.
- `pix_ready` in 1: downstream accepts the beat.
- `pix_x` out 6: unflipped local x.
- `pix_y` out 6: unflipped local y.
- `pix_hsize` out 8: latched `obj_hsize`.
- `pix_vsize` out 8: latched `obj_vsize`.
- `pix_hflip` out 1: latched `obj_hflip`.
- `pix_vflip` out 1: latched `obj_vflip`.
- `pix_screen_x` out 8: screen column of the beat, always < 240.
- `pix_last` out 1: the beat has `pix_x == hsize-1`.
- `obj_done` out 1: one-cycle pulse when an OBJ finishes, whether it hit or missed.
- `obj_hit` out 1: qualifies `obj_done`; 1 = the scanline hit the OBJ.

## Operation
- **Accept.** An accept occurs when `obj_valid && obj_ready` at a clock edge.
  - The walker latches the X position, both sizes and both flip bits.
  - It computes `ly = (vcount - obj_y) mod 256` at 8 bits and `hit = ly < vsize`.
- **States:** IDLE, WALK, DONE.
  - IDLE → WALK on an accepted hit, with `lx = 0` and `pix_y = ly[5:0]`.
  - IDLE → DONE on an accepted miss, with `hit = 0`.
  - WALK: `sx = (obj_x + {3'b0, lx}) mod 512` at 9 bits. The pixel is on-screen iff `sx < 240`.
    - On-screen: `pix_valid = 1`. `lx` advances only when `pix_ready` is high.
    - Off-screen: `pix_valid = 0` and `lx` advances unconditionally, one cycle per skipped pixel.
  - WALK → DONE when `lx` advances while `lx == hsize-1`.
  - DONE: `obj_done = 1` and `obj_hit` equals the latched hit for exactly this one cycle. Next state is IDLE.
- **Flush.** `flush` forces IDLE from any state and takes priority over every transition. A descriptor presented in the same cycle as `flush` is not accepted.
- **Pixel outputs.** `pix_*` are functions of registered state only; no combinational path runs from `pix_ready` to `pix_*`.
  - `pix_x = lx` and `pix_screen_x = sx[7:0]`.
  - `pix_last = (lx == hsize-1)`. If the last pixel is off-screen, no beat carries `pix_last`, and `obj_done` still fires.
- **Handshake.** Beat payload is held stable while `pix_valid && !pix_ready`.
- **Reset values.** State is IDLE, so `obj_ready = 1`. `pix_valid`, `pix_last`, `obj_done` and `obj_hit` are 0. All latched fields and `lx` are 0.
- **Illegal sizes.** Behaviour for sizes outside {8, 16, 32, 64} is undefined; `lx` stops at `hsize-1` and never passes 63.

## Timing
- From the accept edge to the first `pix_valid`: 1 cycle, provided local pixel 0 is on-screen.
- Hit with all pixels on-screen and `pix_ready` held high: `hsize` beats on consecutive cycles. `obj_done` follows in the cycle after the last beat, and `obj_ready` returns one cycle after that.
- Miss: `obj_done` with `obj_hit = 0` in the cycle after the accept, and `obj_ready` high the cycle after that. The total is 2 cycles per missed OBJ.
- Occupancy per hit OBJ: `hsize + 1` cycles of WALK/DONE plus the cycles spent stalled on `pix_ready`.
- A reset during WALK returns to IDLE immediately and asynchronously. All outputs take their reset values and the partial line is discarded.

## Test plan
- **Basic hit.** `vcount=50`, `obj_y=45`, `obj_x=10`, 8×8, `pix_ready=1`.
  - Expect 8 beats with `pix_y=5`, `pix_x` 0..7 and `pix_screen_x` 10..17.
  - `pix_last` is high on the 8th beat, then `obj_done=1` with `obj_hit=1`.
- **Vertical miss and wrap.**
  - `vcount=50`, `obj_y=60`, 16×16: no beats, and `obj_done` fires with `obj_hit=0` one cycle after the accept.
  - `vcount=3`, `obj_y=250`, vsize 16: a hit with `pix_y=9`.
- **Left clip.** `obj_x=500` (−12), hsize 16.
  - 12 silent cycles, then beats with `pix_x` 12..15 and `pix_screen_x` 0..3.
  - Total from accept to `obj_done` is 17 cycles.
- **Right clip.** `obj_x=236`, hsize 8.
  - Beats for `pix_x` 0..3 (`pix_screen_x` 236..239) and no `pix_last` beat.
  - `obj_done` fires after 4 silent cycles.
- **Backpressure.** 8×8 hit with `pix_ready` toggled 1,0,0,1,…
  - Payload is held during each stall.
  - Exactly 8 beats are accepted, with no duplicate or lost `pix_x`.
- **Flush and reset mid-walk.**
  - Assert `flush` at `pix_x=3` of a 32-wide OBJ: next cycle is IDLE, `obj_ready=1`, and no `obj_done`.
  - Repeat with `reset_n` low: all outputs drop to their reset values asynchronously.
